mem_sram_ctrl: RTL and testbench

//  Multi-cycle data-memory controller directly downstream of the MEM stage; replaces the single-cycle data memory.

---
 rtl/mem_sram_ctrl_pkg.sv | 17 +
 rtl/mem_sram_ctrl.sv | 133 +++++++++++++
 tb/tb_mem_sram_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_sram_ctrl_pkg.sv
// Shared constants and state encoding for the two-half-access SRAM data-memory controller.
package mem_sram_ctrl_pkg;

   localparam int DEF_WORD_WIDTH      = 32;
   localparam int DEF_SRAM_DATA_WIDTH = 16;
   localparam int DEF_SRAM_ADDR_WIDTH = 18;
   localparam int DEF_WAIT_CYCLES     = 2;
   localparam int DEF_BASE_ADDR       = 1024;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LO   = 2'd1,
      ST_HI   = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/mem_sram_ctrl.sv
// Runs one 32-bit CPU load/store as two 16-bit accesses (low half, then high half) on an
// async SRAM; ready stays low while an access is outstanding so the pipeline freezes.
module mem_sram_ctrl
   import mem_sram_ctrl_pkg::*;
#(
   parameter int WORD_WIDTH      = DEF_WORD_WIDTH,
   parameter int SRAM_DATA_WIDTH = DEF_SRAM_DATA_WIDTH,
   parameter int SRAM_ADDR_WIDTH = DEF_SRAM_ADDR_WIDTH,
   parameter int WAIT_CYCLES     = DEF_WAIT_CYCLES,
   parameter int BASE_ADDR       = DEF_BASE_ADDR
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       MEM_R_EN,
   input  logic                       MEM_W_EN,
   input  logic [WORD_WIDTH-1:0]      address,
   input  logic [WORD_WIDTH-1:0]      write_data,
   output logic [WORD_WIDTH-1:0]      read_data,
   output logic                       ready,
   output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
   output logic [SRAM_DATA_WIDTH-1:0] sram_dq_out,
   output logic                       sram_dq_oe,
   input  logic [SRAM_DATA_WIDTH-1:0] sram_dq_in,
   output logic                       sram_we_n,
   output logic                       sram_oe_n
);

   localparam int CNT_W  = $clog2(WAIT_CYCLES + 1);
   localparam int HALF_W = SRAM_ADDR_WIDTH - 1;

   state_t                    state;
   logic [CNT_W-1:0]          cnt;
   logic                      op_wr;
   logic [HALF_W-1:0]         half_base;
   logic [WORD_WIDTH-1:0]     wdata;
   logic                      req;
   logic                      last;
   logic [WORD_WIDTH-1:0]     phys;
   logic                      unused_phys;

   assign req  = MEM_R_EN | MEM_W_EN;
   assign last = (cnt == CNT_W'(WAIT_CYCLES - 1));
   // Byte address relative to the SRAM window; wraps mod 2^32 and the top bits simply drop off.
   assign phys = address - WORD_WIDTH'(BASE_ADDR);
   assign unused_phys = ^{phys[WORD_WIDTH-1:SRAM_ADDR_WIDTH+1], phys[1:0]};

   function automatic logic [SRAM_ADDR_WIDTH-1:0] half_addr(input logic [HALF_W-1:0] base,
                                                          input logic hi);
      return {base, hi};
   endfunction

   always_comb begin
      ready = 1'b0;
      case (state)
         ST_IDLE: ready = ~req;
         ST_DONE: ready = 1'b1;
         default: ready = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         op_wr       <= 1'b0;
         half_base   <= '0;
         wdata       <= '0;
         read_data   <= '0;
         sram_addr   <= '0;
         sram_dq_out <= '0;
         sram_dq_oe  <= 1'b0;
         sram_we_n   <= 1'b1;
         sram_oe_n   <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req) begin
                  state     <= ST_LO;
                  cnt       <= '0;
                  op_wr     <= MEM_W_EN;
                  half_base <= phys[SRAM_ADDR_WIDTH:2];
                  wdata     <= write_data;
                  sram_addr <= half_addr(phys[SRAM_ADDR_WIDTH:2], 1'b0);
                  // Simultaneous read and write requests resolve to a write.
                  if (MEM_W_EN) begin
                     sram_we_n   <= 1'b0;
                     sram_oe_n   <= 1'b1;
                     sram_dq_oe  <= 1'b1;
                     sram_dq_out <= write_data[SRAM_DATA_WIDTH-1:0];
                  end else begin
                     sram_we_n   <= 1'b1;
                     sram_oe_n   <= 1'b0;
                     sram_dq_oe  <= 1'b0;
                  end
               end
            end
            ST_LO: begin
               if (last) begin
                  state     <= ST_HI;
                  cnt       <= '0;
                  sram_addr <= half_addr(half_base, 1'b1);
                  if (op_wr) sram_dq_out <= wdata[WORD_WIDTH-1:SRAM_DATA_WIDTH];
                  else       read_data[SRAM_DATA_WIDTH-1:0] <= sram_dq_in;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_HI: begin
               if (last) begin
                  state      <= ST_DONE;
                  cnt        <= '0;
                  sram_we_n  <= 1'b1;
                  sram_oe_n  <= 1'b1;
                  sram_dq_oe <= 1'b0;
                  if (!op_wr) read_data[WORD_WIDTH-1:SRAM_DATA_WIDTH] <= sram_dq_in;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_DONE: begin
               // A request still held here is the one just served; the next is taken in IDLE.
               state <= ST_IDLE;
               cnt   <= '0;
            end
            default: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Bench for mem_sram_ctrl: behavioural SRAM on the sram_* pins, directed vector table,
// multi-cycle corner sequences and randomized traffic against a word-level memory model.
module tb_mem_sram_ctrl;

   localparam int W = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        MEM_R_EN = 1'b0;
   logic        MEM_W_EN = 1'b0;
   logic [31:0] address = '0;
   logic [31:0] write_data = '0;
   logic [31:0] read_data;
   logic        ready;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out;
   logic        sram_dq_oe;
   logic [15:0] sram_dq_in = '0;
   logic        sram_we_n;
   logic        sram_oe_n;

   mem_sram_ctrl #(.WAIT_CYCLES(W)) dut (
      .clk(clk), .rst(rst), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
      .address(address), .write_data(write_data), .read_data(read_data), .ready(ready),
      .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
      .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
   );

   always #5 clk = ~clk;

   // Behavioural SRAM: half-word store, writes on we_n low, read data presented mid-cycle.
   logic [15:0] sram [int];
   logic [20:0] acc_q [$];

   function automatic logic [15:0] sram_get(input int a);
      if (sram.exists(a)) return sram[a];
      return 16'h0;
   endfunction

   always @(posedge clk) begin
      if (!sram_we_n) sram[int'(sram_addr)] = sram_dq_out;
      if (!sram_we_n || !sram_oe_n) acc_q.push_back({~sram_we_n, ~sram_oe_n, sram_dq_oe, sram_addr});
   end

   always @(negedge clk)
      sram_dq_in <= sram_oe_n ? 16'h0 : sram_get(int'(sram_addr));

   // Word-level reference model
   logic [31:0] ref_mem [int];
   logic [31:0] last_rd = '0;
   int total = 0;
   int bad = 0;

   function automatic int widx(input logic [31:0] a);
      logic [31:0] p;
      p = (a - 32'd1024) >> 2;
      return int'(p % 32'd131072);
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      if (ref_mem.exists(widx(a))) return ref_mem[widx(a)];
      return 32'h0;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", nm, act, exp);
      end
   endtask

   task automatic wait_ready(output int lc);
      lc = 0;
      while (!ready && lc < 50) begin
         lc++;
         @(negedge clk); #1;
      end
   endtask

   task automatic run_vec(input string nm, input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] exp_rd, input int exp_lo);
      int lc;
      logic [31:0] got;
      acc_q.delete();
      @(negedge clk);
      MEM_R_EN = r; MEM_W_EN = w; address = a; write_data = d;
      #1;
      wait_ready(lc);
      got = read_data;
      MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
      check({nm, " ready-low"}, 32'(lc), 32'(1 + 2 * W));
      check({nm, " rdata"}, got, exp_rd);
      check({nm, " nacc"}, 32'(acc_q.size()), 32'(2 * W));
      for (int i = 0; i < acc_q.size() && i < 2 * W; i++)
         check({nm, " acc"}, 32'(acc_q[i]),
               32'({w, ~w, w, 18'(exp_lo + ((i >= W) ? 1 : 0))}));
      if (w) begin
         check({nm, " sram lo"}, 32'(sram_get(exp_lo)), 32'(d[15:0]));
         check({nm, " sram hi"}, 32'(sram_get(exp_lo + 1)), 32'(d[31:16]));
         ref_mem[widx(a)] = d;
      end else begin
         last_rd = exp_rd;
      end
   endtask

   typedef struct {
      logic        r;
      logic        w;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp_rd;
      int          exp_lo;
   } vec_t;

   vec_t vecs [10];

   initial begin
      int lc;
      int op;
      logic [31:0] a, d, e;

      vecs[0] = '{1'b0, 1'b1, 32'h0000_0400, 32'hDEAD_BEEF, 32'h0000_0000, 0};
      vecs[1] = '{1'b1, 1'b0, 32'h0000_0400, 32'h0,         32'hDEAD_BEEF, 0};
      vecs[2] = '{1'b1, 1'b0, 32'h0000_040C, 32'h0,         32'h0000_0000, 6};
      vecs[3] = '{1'b0, 1'b1, 32'h0000_040C, 32'hCAFE_F00D, 32'h0000_0000, 6};
      vecs[4] = '{1'b1, 1'b0, 32'h0000_040E, 32'h0,         32'hCAFE_F00D, 6};
      vecs[5] = '{1'b1, 1'b1, 32'h0000_0408, 32'h1234_5678, 32'hCAFE_F00D, 4};
      vecs[6] = '{1'b1, 1'b0, 32'h0000_0408, 32'h0,         32'h1234_5678, 4};
      vecs[7] = '{1'b0, 1'b1, 32'h0000_03FC, 32'h0BAD_C0DE, 32'h1234_5678, 18'h3FFFE};
      vecs[8] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0,         32'h0BAD_C0DE, 18'h3FFFE};
      vecs[9] = '{1'b1, 1'b0, 32'h0008_0400, 32'h0,         32'hDEAD_BEEF, 0};

      // Reset values
      repeat (2) @(negedge clk);
      #1;
      check("rst rdata", read_data, 32'h0);
      check("rst addr", 32'(sram_addr), 32'h0);
      check("rst we_n", 32'(sram_we_n), 32'h1);
      check("rst oe_n", 32'(sram_oe_n), 32'h1);
      check("rst dq_oe", 32'(sram_dq_oe), 32'h0);
      @(negedge clk);
      rst = 1'b1;

      // Idle: no request for 10 cycles
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         check("idle ready", 32'(ready), 32'h1);
         check("idle we_n", 32'(sram_we_n), 32'h1);
         check("idle oe_n", 32'(sram_oe_n), 32'h1);
         check("idle dq_oe", 32'(sram_dq_oe), 32'h0);
      end

      // Directed vector table
      for (int i = 0; i < 10; i++)
         run_vec($sformatf("vec%0d", i), vecs[i].r, vecs[i].w, vecs[i].addr, vecs[i].data,
                 vecs[i].exp_rd, vecs[i].exp_lo);

      // Request held through DONE, next read presented in the following cycle
      acc_q.delete();
      @(negedge clk);
      MEM_R_EN = 1'b1; address = 32'h400;
      #1;
      wait_ready(lc);
      check("hold1 ready-low", 32'(lc), 32'(1 + 2 * W));
      check("hold1 rdata", read_data, ref_rd(32'h400));
      @(negedge clk);
      address = 32'h404;
      #1;
      check("hold2 start ready", 32'(ready), 32'h0);
      wait_ready(lc);
      check("hold2 ready-low", 32'(lc), 32'(1 + 2 * W));
      check("hold2 rdata", read_data, ref_rd(32'h404));
      last_rd = ref_rd(32'h404);
      MEM_R_EN = 1'b0;
      repeat (2) @(negedge clk);
      check("hold nacc", 32'(acc_q.size()), 32'(4 * W));
      for (int i = 0; i < acc_q.size() && i < 4 * W; i++)
         check("hold acc addr", 32'(acc_q[i][17:0]), 32'(i / W));

      // Inputs changed mid-access are ignored
      acc_q.delete();
      @(negedge clk);
      MEM_W_EN = 1'b1; address = 32'h410; write_data = 32'hA5A5_5A5A;
      #1;
      @(negedge clk);
      MEM_W_EN = 1'b0; MEM_R_EN = 1'b1; address = 32'h500; write_data = 32'hFFFF_0000;
      #1;
      wait_ready(lc);
      MEM_R_EN = 1'b0;
      check("mid ready-low", 32'(lc), 32'(2 * W));
      check("mid rdata", read_data, last_rd);
      check("mid sram lo", 32'(sram_get(8)), 32'h5A5A);
      check("mid sram hi", 32'(sram_get(9)), 32'hA5A5);
      check("mid sram other", 32'(sram_get(32'h80)), 32'h0);
      check("mid nacc", 32'(acc_q.size()), 32'(2 * W));
      ref_mem[widx(32'h410)] = 32'hA5A5_5A5A;

      // Randomized traffic against the word model
      for (int i = 0; i < 40; i++) begin
         op = int'($urandom_range(0, 2));
         a = 32'h400 + ($urandom_range(0, 63) << 2) + $urandom_range(0, 3);
         d = $urandom;
         e = (op == 0) ? ref_rd(a) : last_rd;
         run_vec($sformatf("rnd%0d", i), (op != 1), (op != 0), a, d, e, 2 * widx(a));
      end

      // Reset during the HI half of a read
      @(negedge clk);
      MEM_R_EN = 1'b1; address = 32'h410;
      repeat (W + 1) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rstmid rdata", read_data, 32'h0);
      check("rstmid we_n", 32'(sram_we_n), 32'h1);
      check("rstmid oe_n", 32'(sram_oe_n), 32'h1);
      check("rstmid dq_oe", 32'(sram_dq_oe), 32'h0);
      check("rstmid addr", 32'(sram_addr), 32'h0);
      check("rstmid ready req", 32'(ready), 32'h0);
      MEM_R_EN = 1'b0;
      #1;
      check("rstmid ready idle", 32'(ready), 32'h1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("post ready", 32'(ready), 32'h1);
      MEM_W_EN = 1'b1;
      #1;
      check("post ready req", 32'(ready), 32'h0);
      MEM_W_EN = 1'b0;
      @(negedge clk); #1;
      check("post we_n", 32'(sram_we_n), 32'h1);
      check("post ready end", 32'(ready), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
